// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store front end over a word array with
// byte-lane writes and fixed wait states. Define DMEM_RESP_MISALIGN_EN to flag alignment/lane errors.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  we_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [29:0]   widx;
  logic [AW-1:0] idx;
  logic          rng_err, fmt_err, err, wr_en;
  logic          unused_bits;

  assign off     = addr_q - ADDR_BASE;
  assign widx    = off[31:2];
  assign idx     = widx[AW-1:0];
  // Full word index is compared so out-of-range addresses never alias into the array.
  assign rng_err = (addr_q < ADDR_BASE) || (widx >= 30'(DEPTH_WORDS));

`ifdef DMEM_RESP_MISALIGN_EN
  logic [1:0] size_q;
  logic [2:0] pop;
  assign pop = 3'(we_q[0]) + 3'(we_q[1]) + 3'(we_q[2]) + 3'(we_q[3]);
  // Lane-count checks apply to stores only; a zero mask is a plain load.
  always_comb begin
    fmt_err = 1'b0;
    case (size_q)
      2'b00:   fmt_err = (we_q != 4'b0) && (pop != 3'd1);
      2'b01:   fmt_err = addr_q[0] ||
                         ((we_q != 4'b0) && (we_q != 4'b0011) && (we_q != 4'b1100));
      default: fmt_err = (addr_q[1:0] != 2'b0) ||
                         ((we_q != 4'b0) && (we_q != 4'b1111));
    endcase
  end
  assign unused_bits = ^off[1:0];
`else
  assign fmt_err     = 1'b0;
  assign unused_bits = ^{off[1:0], req_size};
`endif

  assign err       = rng_err | fmt_err;
  assign wr_en     = (state == ACCESS) && !err && (we_q != 4'b0) && !reset;
  assign req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (we_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          addr_q  <= req_addr;
          we_q    <= req_we;
          wdata_q <= req_wdata;
`ifdef DMEM_RESP_MISALIGN_EN
          size_q  <= req_size;
`endif
          if (WAIT_STATES == 0) state <= ACCESS;
          else begin
            state <= WAIT;
            cnt   <= 4'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || (we_q != 4'b0)) ? 32'd0 : mem[idx];
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses, a negedge
// monitor pops and compares on every rsp handshake; directed checks cover latency, stall and reset.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_we;
  logic [1:0]  req_size;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q [$];

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  task automatic accept(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [1:0] sz);
    int w = 0;
    @(negedge clk);
    req_addr = a; req_we = we; req_wdata = wd; req_size = sz; req_valid = 1'b1;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic await_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", n, 32'd3);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [31:0] ed, input logic ee);
    accept(a, we, wd, sz);
    exp_q.push_back({ee, ed});
    await_rsp();
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_valid || !req_ready) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
    req_addr = 0; req_we = 0; req_wdata = 0; req_size = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    do_req(32'h10, 4'b1111, 32'hDEADBEEF, 2'b10, 32'h0, 1'b0);
    do_req(32'h10, 4'b0000, 32'h0,        2'b10, 32'hDEADBEEF, 1'b0);
    do_req(32'h11, 4'b0010, 32'hABABABAB, 2'b00, 32'h0, 1'b0);
    do_req(32'h10, 4'b0000, 32'h0,        2'b10, 32'hDEADABEF, 1'b0);

    // Response stall with a competing request held on the bus.
    drain();
    rsp_ready = 1'b0;
    do_req(32'h10, 4'b0000, 32'h0, 2'b10, 32'hDEADABEF, 1'b0);
    req_addr = 32'h10; req_we = 0; req_wdata = 0; req_size = 2'b10; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEADABEF);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready_pre", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("hs_req_ready_post", {31'd0, req_ready}, 32'd1);
    chk("hs_valid_drop", {31'd0, rsp_valid}, 32'd0);
    exp_q.push_back({1'b0, 32'hDEADABEF});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("second_accepted", {31'd0, req_ready}, 32'd0);
    await_rsp();

    do_req(32'h1000, 4'b0000, 32'h0,        2'b10, 32'h0, 1'b1);
    do_req(32'h1000, 4'b1111, 32'hFFFFFFFF, 2'b10, 32'h0, 1'b1);
    do_req(32'h10,   4'b0000, 32'h0,        2'b10, 32'hDEADABEF, 1'b0);

    // Store dropped by reset while waiting must not reach the array.
    do_req(32'h20, 4'b1111, 32'h11112222, 2'b10, 32'h0, 1'b0);
    drain();
    accept(32'h20, 4'b1111, 32'h12345678, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready_rel", {31'd0, req_ready}, 32'd1);
    do_req(32'h20, 4'b0000, 32'h0, 2'b10, 32'h11112222, 1'b0);

`ifdef DMEM_RESP_MISALIGN_EN
    do_req(32'h12, 4'b0000, 32'h0, 2'b10, 32'h0, 1'b1);
`else
    do_req(32'h12, 4'b0000, 32'h0, 2'b10, 32'hDEADABEF, 1'b0);
`endif

    drain();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
